// File: rtl/layer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : layer_ctrl
//  Brief    : Sequencer for one fully-connected layer. It streams numWeight
//             input samples to numNeurons neurons in parallel. It freezes or
//             pauses the neurons between beats, then captures their outputs
//             into a result register held until the consumer takes it.
//  Revision : 1.0  initial release
// ============================================================================
module layer_ctrl #(
    parameter int numWeight  = 784,
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [dataWidth-1:0]            in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic                            freeze,
    output logic                            pause,
    output logic [dataWidth-1:0]            neuron_in,
    input  logic [numNeurons*dataWidth-1:0] neuron_out,
    output logic [numNeurons*dataWidth-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            err_len
);

    // Beat counter width; a one-beat layer still needs a 1-bit counter.
    localparam int                 c_cnt_w     = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(numWeight - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_run     = 2'd1;
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_hold    = 2'd3;

    logic [1:0]                      r_state;
    logic [1:0]                      w_state_nxt;
    logic [c_cnt_w-1:0]              r_beat_cnt;
    logic                            r_err_len;
    logic [numNeurons*dataWidth-1:0] r_out_data;
    logic                            w_accept;
    logic                            w_last_beat;

    assign w_accept    = in_valid & in_ready;
    assign w_last_beat = (r_beat_cnt == c_last_beat);

    // Samples go straight through; neurons only act on them while unfrozen and unpaused.
    assign neuron_in = in_data;
    assign out_data  = r_out_data;
    assign err_len   = r_err_len;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start only counts in IDLE, HOLD waits for the consumer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (start) w_state_nxt = c_st_run;
            c_st_run:     if (w_accept && w_last_beat) w_state_nxt = c_st_capture;
            c_st_capture: w_state_nxt = c_st_hold;
            c_st_hold:    if (out_ready) w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    // Output decode: neurons are frozen (cleared) everywhere except RUN.
    always_comb begin
        freeze    = 1'b1;
        pause     = 1'b1;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_st_run: begin
                freeze   = 1'b0;
                pause    = ~in_valid;
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            c_st_capture: begin
                busy = 1'b1;
            end
            c_st_hold: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Beat counting and length checking; a bad in_last never changes the beat count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_err_len  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_beat_cnt <= '0;
                        r_err_len  <= 1'b0;
                    end
                end
                c_st_run: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
                        end
                        if (in_last != w_last_beat) begin
                            r_err_len <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_beat_cnt <= r_beat_cnt;
                end
            endcase
        end
    end

    // Result register: loaded only at the end of CAPTURE, stable through HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data <= '0;
        end else if (r_state == c_st_capture) begin
            r_out_data <= neuron_out;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_layer_ctrl
//  Brief    : Directed bench for layer_ctrl with a 4-beat, 3-neuron layer.
//             A behavioural neuron array (Q4.11 MAC + bias + ReLU) reacts to
//             freeze/pause so sequencing faults show up in the result.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_ctrl;

    localparam int NW = 4;
    localparam int NN = 3;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              freeze;
    logic              pause;
    logic [DW-1:0]     neuron_in;
    logic [NN*DW-1:0]  neuron_out;
    logic [NN*DW-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err_len;

    int n_checks = 0;
    int n_pass   = 0;

    // Streams: A = 1.0, 0.5, -0.25, 2.0 ; B = 0.5 x4 (Q4.11)
    logic [DW-1:0] stream_a [NW] = '{16'h0800, 16'h0400, 16'hFE00, 16'h1000};
    logic [DW-1:0] stream_b [NW] = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};

    // n0: w=1.0 x4, b=0 ; n1: w=0.5,-1.0,2.0,0.25, b=0.25 ; n2: w=-1.0 x4, b=0
    // A: n0=3.25 (1A00), n1=0+0.25 (0200), n2=-3.25 -> 0
    // B: n0=2.0 (1000),  n1=0.875+0.25 (0900), n2=-2.0 -> 0
    localparam logic [NN*DW-1:0] EXP_A = {16'h0000, 16'h0200, 16'h1A00};
    localparam logic [NN*DW-1:0] EXP_B = {16'h0000, 16'h0900, 16'h1000};

    logic signed [15:0] wt   [NN][NW];
    logic signed [31:0] bias [NN];
    logic signed [31:0] acc  [NN];
    logic [1:0]         waddr;

    initial begin
        wt[0] = '{16'sh0800, 16'sh0800, 16'sh0800, 16'sh0800};
        wt[1] = '{16'sh0400, 16'shF800, 16'sh1000, 16'sh0200};
        wt[2] = '{16'shF800, 16'shF800, 16'shF800, 16'shF800};
        bias  = '{32'sd0, 32'sd512, 32'sd0};
    end

    always #5 clk = ~clk;

    // Behavioural neurons: clear on freeze, hold on pause, else MAC one beat.
    always @(posedge clk) begin
        if (freeze) begin
            for (int k = 0; k < NN; k++) acc[k] <= 32'sd0;
            waddr <= 2'd0;
        end else if (!pause) begin
            for (int k = 0; k < NN; k++)
                acc[k] <= acc[k] + (($signed(neuron_in) * wt[k][waddr]) >>> 11);
            waddr <= waddr + 2'd1;
        end
    end

    for (genvar k = 0; k < NN; k++) begin : g_neuron_out
        logic signed [31:0] w_sum;
        assign w_sum = acc[k] + bias[k];
        assign neuron_out[k*DW +: DW] = w_sum[31] ? '0 : w_sum[DW-1:0];
    end

    layer_ctrl #(.numWeight(NW), .numNeurons(NN), .dataWidth(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .freeze(freeze), .pause(pause), .neuron_in(neuron_in), .neuron_out(neuron_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_len(err_len)
    );

    // Stimulus helpers (drive only). All are entered and left just after a negedge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beats(input logic [DW-1:0] d [NW], input logic [NW-1:0] lastm);
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1; in_data = d[i]; in_last = lastm[i];
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (freeze !== 1'b1) $display("FAIL reset_freeze: got %b want 1", freeze); else n_pass++;
        n_checks++; if (pause !== 1'b1) $display("FAIL reset_pause: got %b want 1", pause); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (err_len !== 1'b0) $display("FAIL reset_err_len: got %b want 0", err_len); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (dut.r_beat_cnt !== 2'd0) $display("FAIL reset_beat_cnt: got %0d want 0", dut.r_beat_cnt); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_no_start_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        do_start(); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL run_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL run_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (freeze !== 1'b0) $display("FAIL run_freeze: got %b want 0", freeze); else n_pass++;
        n_checks++; if (pause !== 1'b1) $display("FAIL run_idle_pause: got %b want 1", pause); else n_pass++;
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1; in_data = stream_a[i]; in_last = (i == NW - 1);
            #1;
            n_checks++; if (pause !== 1'b0) $display("FAIL basic_pause beat %0d: got %b want 0", i, pause); else n_pass++;
            n_checks++; if (neuron_in !== stream_a[i]) $display("FAIL basic_neuron_in beat %0d: got %h want %h", i, neuron_in, stream_a[i]); else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL capture_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL capture_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (freeze !== 1'b1) $display("FAIL capture_freeze: got %b want 1", freeze); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL capture_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (dut.r_beat_cnt !== 2'd0) $display("FAIL capture_beat_cnt: got %0d want 0", dut.r_beat_cnt); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== EXP_A) $display("FAIL basic_out_data: got %h want %h", out_data, EXP_A); else n_pass++;
        n_checks++; if (err_len !== 1'b0) $display("FAIL basic_err_len: got %b want 0", err_len); else n_pass++;
        n_checks++; if (pause !== 1'b1) $display("FAIL hold_pause: got %b want 1", pause); else n_pass++;
        handshake(); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_idle_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_pause();
        do_start();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = stream_a[i]; in_last = 1'b0;
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            in_valid = 1'b0; in_data = 16'h7FFF; in_last = 1'b0;
            #1;
            n_checks++; if (pause !== 1'b1) $display("FAIL gap_pause cycle %0d: got %b want 1", g, pause); else n_pass++;
            n_checks++; if (dut.r_beat_cnt !== 2'd2) $display("FAIL gap_beat_cnt cycle %0d: got %0d want 2", g, dut.r_beat_cnt); else n_pass++;
            @(negedge clk);
        end
        for (int i = 2; i < NW; i++) begin
            in_valid = 1'b1; in_data = stream_a[i]; in_last = (i == NW - 1);
            #1;
            n_checks++; if (pause !== 1'b0) $display("FAIL gap_resume_pause beat %0d: got %b want 0", i, pause); else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL gap_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== EXP_A) $display("FAIL gap_out_data: got %h want %h", out_data, EXP_A); else n_pass++;
        handshake();
    endtask

    task automatic test_err_len();
        do_start();
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1; in_data = stream_a[i]; in_last = (i == 1) || (i == NW - 1);
            @(negedge clk); #1;
            if (i == 0) begin
                n_checks++; if (err_len !== 1'b0) $display("FAIL early_last_pre: got %b want 0", err_len); else n_pass++;
            end
            if (i == 1) begin
                n_checks++; if (err_len !== 1'b1) $display("FAIL early_last_set: got %b want 1", err_len); else n_pass++;
                n_checks++; if (in_ready !== 1'b1) $display("FAIL early_last_still_run: got %b want 1", in_ready); else n_pass++;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL early_last_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== EXP_A) $display("FAIL early_last_out_data: got %h want %h", out_data, EXP_A); else n_pass++;
        handshake(); #1;
        n_checks++; if (err_len !== 1'b1) $display("FAIL err_len_sticky_idle: got %b want 1", err_len); else n_pass++;
    endtask

    task automatic test_missing_last();
        do_start(); #1;
        n_checks++; if (err_len !== 1'b0) $display("FAIL start_clears_err_len: got %b want 0", err_len); else n_pass++;
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1; in_data = stream_b[i]; in_last = 1'b0;
            @(negedge clk); #1;
            if (i == NW - 2) begin
                n_checks++; if (err_len !== 1'b0) $display("FAIL missing_last_pre: got %b want 0", err_len); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (err_len !== 1'b1) $display("FAIL missing_last_set: got %b want 1", err_len); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL missing_last_out_valid: got %b want 1", out_valid); else n_pass++;
        handshake();
    endtask

    task automatic test_hold_stall();
        do_start();
        send_beats(stream_a, 4'b1000);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            start = (c % 2 == 0);
            #1;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid cycle %0d: got %b want 1", c, out_valid); else n_pass++;
            n_checks++; if (out_data !== EXP_A) $display("FAIL stall_out_data cycle %0d: got %h want %h", c, out_data, EXP_A); else n_pass++;
            @(negedge clk);
        end
        start = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_start_ignored: got %b want 1", out_valid); else n_pass++;
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_release_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL stall_release_busy: got %b want 0", busy); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL handshake_start_dropped_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL handshake_start_dropped_in_ready: got %b want 0", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        do_start();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = stream_a[i]; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (freeze !== 1'b1) $display("FAIL midrst_freeze: got %b want 1", freeze); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (dut.r_beat_cnt !== 2'd0) $display("FAIL midrst_beat_cnt: got %0d want 0", dut.r_beat_cnt); else n_pass++;
        rst_n = 1'b1;
        do_start();
        send_beats(stream_a, 4'b1000);
        @(negedge clk); #1;
        n_checks++; if (out_data !== EXP_A) $display("FAIL midrst_rerun_out_data: got %h want %h", out_data, EXP_A); else n_pass++;
        n_checks++; if (err_len !== 1'b0) $display("FAIL midrst_rerun_err_len: got %b want 0", err_len); else n_pass++;
        handshake();
    endtask

    task automatic test_back_to_back();
        do_start();
        send_beats(stream_a, 4'b1000);
        @(negedge clk); #1;
        n_checks++; if (out_data !== EXP_A) $display("FAIL b2b_first_out_data: got %h want %h", out_data, EXP_A); else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_first_idle_busy: got %b want 0", busy); else n_pass++;
        do_start(); #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_second_busy: got %b want 1", busy); else n_pass++;
        send_beats(stream_b, 4'b1000);
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_second_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== EXP_B) $display("FAIL b2b_second_out_data: got %h want %h", out_data, EXP_B); else n_pass++;
        handshake();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_data = '0; in_valid = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_pause();
        test_err_len();
        test_missing_last();
        test_hold_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_ctrl.md
LAYER_CTRL -- requirements
Module: layer_ctrl

Interface
REQ-001 SHALL have parameter numWeight, default 784: input beats per inference.
REQ-002 SHALL have parameter numNeurons, default 30: neurons driven in parallel.
REQ-003 SHALL have parameter dataWidth, default 16: fixed-point sample width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin one inference.
REQ-007 SHALL have ports in_data (input, dataWidth), in_valid (input, 1), in_last (input, 1) and in_ready (output, 1): the input sample stream.
REQ-008 SHALL have ports freeze (output, 1), pause (output, 1) and neuron_in (output, dataWidth): broadcast to all neurons.
REQ-009 SHALL have port neuron_out, input, numNeurons*dataWidth: neuron k output at bits [k*dataWidth +: dataWidth].
REQ-010 SHALL have ports out_data (output, numNeurons*dataWidth), out_valid (output, 1) and out_ready (input, 1): the result stream.
REQ-011 SHALL have ports busy (output, 1) and err_len (output, 1): status flags.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, CAPTURE and HOLD.
REQ-013 IDLE SHALL drive freeze=1, pause=1, in_ready=0 and busy=0; start=1 SHALL move it to RUN and clear beat_cnt and err_len.
REQ-014 RUN SHALL drive freeze=0, in_ready=1, pause=~in_valid, neuron_in=in_data (combinational) and busy=1.
REQ-015 A beat SHALL be accepted when in_valid & in_ready; each accepted beat SHALL increment beat_cnt, which is $clog2(numWeight) bits wide.
REQ-016 A cycle in RUN with in_valid=0 SHALL hold beat_cnt and assert pause, so the neurons hold their accumulators and weight addresses.
REQ-017 Acceptance of beat numWeight-1 SHALL move RUN to CAPTURE and reset beat_cnt to 0; beat_cnt SHALL never wrap inside RUN.
REQ-018 in_last=1 on an accepted beat other than beat numWeight-1, or in_last=0 on beat numWeight-1, SHALL set err_len (sticky).
REQ-019 An err_len event SHALL NOT alter sequencing: exactly numWeight beats are always consumed.
REQ-020 CAPTURE SHALL last one cycle, drive freeze=1, pause=1, in_ready=0 and busy=1, and register neuron_out into out_data at its end; the state then goes to HOLD.
REQ-021 HOLD SHALL drive out_valid=1, freeze=1, pause=1, in_ready=0 and busy=1, and keep out_data stable.
REQ-022 HOLD SHALL return to IDLE on out_valid & out_ready.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 A start coinciding with the HOLD->IDLE handshake SHALL be dropped.
REQ-025 Latency: last beat accepted at edge T -> out_valid=1 in the cycle after edge T+1.
REQ-026 Minimum inference time SHALL be numWeight+2 cycles from start to out_valid.
REQ-027 out_valid SHALL be 0 in every state except HOLD.
REQ-028 out_data SHALL change only on the CAPTURE edge.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-RUN.
REQ-030 The state after reset SHALL be: freeze=1, pause=1, in_ready=0, out_valid=0, busy=0, err_len=0, beat_cnt=0, out_data=0.
REQ-031 Holding freeze=1 in IDLE after a mid-RUN reset SHALL clear neuron accumulator state before the next start.

Verification
REQ-032 numWeight=4, start, then 4 contiguous beats 1.0/0.5/-0.25/2.0 (Q4.11) with in_last on beat 3 -> out_valid 2 cycles after beat 3; out_data matches the model ReLU(sum+bias); err_len=0.
REQ-033 Same stream with in_valid=0 for 3 cycles after beat 1 -> pause=1 during the gap only, beat_cnt held at 2, out_data identical to REQ-032.
REQ-034 in_last on beat 1 of 4 -> err_len=1; 4 beats still consumed; out_valid asserted normally.
REQ-035 out_ready=0 for 5 cycles in HOLD -> out_valid and out_data stable; start pulses ignored; IDLE entered on the cycle after out_ready=1.
REQ-036 rst_n=0 after beat 2 -> next cycle IDLE, freeze=1, out_valid=0; a fresh 4-beat run then matches REQ-032.
REQ-037 Back-to-back runs with start issued on the first IDLE cycle -> second result independent of the first, with no accumulator carry-over.
